pwm_uart_tx: RTL and testbench

//  UART transmitter for the PWM sine core: serialises status/echo bytes onto uart_txd.
//  It is the transmit-side counterpart to the core's UART receive path.

---
 rtl/pwm_uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/pwm_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_pwm_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_uart_pkg.sv
// Shared types and constants for the PWM core's UART transmitter.
package pwm_uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    localparam int unsigned LEVEL_W = 5;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter; power-of-two depth, async reset.
module uart_tx_fifo
    import pwm_uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   wdata_i,
    input  logic               pop_i,
    output logic [WIDTH-1:0]   rdata_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (level_q == LEVEL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guarded here so a push against a full FIFO can never overwrite queued data.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pwm_uart_tx.sv
// UART transmitter: valid/ready byte port, FIFO, baud counter and frame FSM with registered TX.
module pwm_uart_tx
    import pwm_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned PARITY       = PAR_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic         clk1_i,
    input  logic         rst_i,
    input  logic [7:0]   tx_data_i,
    input  logic         tx_valid_i,
    output logic         tx_ready_o,
    output logic         uart_txd_o,
    output logic         tx_busy_o,
    output logic [4:0]   fifo_level_o
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP   = 3'(STOP_BITS - 1);
    localparam logic        ODD_PARITY  = (PARITY == PAR_ODD);

    tx_state_e    state_q, state_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [2:0]   bit_idx_q, bit_idx_d;
    logic [7:0]   shift_q, shift_d;
    logic         par_q, par_d;
    logic         txd_q, txd_d;
    logic         load_frame;

    logic         fifo_pop;
    logic [7:0]   fifo_rdata;
    logic         fifo_full;
    logic         fifo_empty;
    logic [4:0]   fifo_level;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk1_i),
        .rst_i   (rst_i),
        .push_i  (tx_valid_i),
        .wdata_i (tx_data_i),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        load_frame = 1'b0;

        unique case (state_q)
            StIdle: begin
                load_frame = !fifo_empty;
            end
            StStart: begin
                if (cnt_q == '0) begin
                    cnt_d     = BAUD_RELOAD;
                    bit_idx_d = '0;
                    state_d   = StData;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    cnt_d = BAUD_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? StParity : StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StParity: begin
                if (cnt_q == '0) begin
                    cnt_d     = BAUD_RELOAD;
                    bit_idx_d = '0;
                    state_d   = StStop;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                // Stop bits are counted individually so the 16-bit counter never needs 2x range.
                if (cnt_q == '0) begin
                    if (bit_idx_q == LAST_STOP) begin
                        load_frame = !fifo_empty;
                        state_d    = StIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        cnt_d     = BAUD_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load_frame) begin
            shift_d   = fifo_rdata;
            par_d     = (^fifo_rdata) ^ ODD_PARITY;
            cnt_d     = BAUD_RELOAD;
            bit_idx_d = '0;
            state_d   = StStart;
        end
    end

    assign fifo_pop = load_frame;

    // Line level follows the current state one cycle later, keeping every bit full length.
    always_comb begin
        txd_d = 1'b1;
        unique case (state_q)
            StIdle:   txd_d = 1'b1;
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_q[0];
            StParity: txd_d = par_q;
            StStop:   txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk1_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            txd_q     <= txd_d;
        end
    end

    assign uart_txd_o   = txd_q;
    assign tx_ready_o   = !fifo_full;
    assign fifo_level_o = fifo_level;
    assign tx_busy_o    = (state_q != StIdle) | (fifo_level != '0);

endmodule

// File: tb/tb_pwm_uart_tx.sv
// Directed bench for pwm_uart_tx: four instances cover no/even/odd parity and two stop bits.
module tb_pwm_uart_tx;

    logic       clk1;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;

    logic [3:0] ready_w;
    logic [3:0] txd_w;
    logic [3:0] busy_w;
    logic [4:0] level_w [4];

    int n_checks = 0;
    int n_errors = 0;

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // 0: no parity, 1 stop; 1: even; 2: odd; 3: no parity, 2 stops.
    pwm_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk1_i(clk1), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(ready_w[0]), .uart_txd_o(txd_w[0]), .tx_busy_o(busy_w[0]),
        .fifo_level_o(level_w[0])
    );
    pwm_uart_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk1_i(clk1), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(ready_w[1]), .uart_txd_o(txd_w[1]), .tx_busy_o(busy_w[1]),
        .fifo_level_o(level_w[1])
    );
    pwm_uart_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk1_i(clk1), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(ready_w[2]), .uart_txd_o(txd_w[2]), .tx_busy_o(busy_w[2]),
        .fifo_level_o(level_w[2])
    );
    pwm_uart_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
        .clk1_i(clk1), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(ready_w[3]), .uart_txd_o(txd_w[3]), .tx_busy_o(busy_w[3]),
        .fifo_level_o(level_w[3])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] frame10(input logic [7:0] d);
        return {1'b1, d, 1'b0};
    endfunction

    task automatic do_reset();
        @(negedge clk1);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        @(posedge clk1);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge clk1);
        #1;
        tx_valid = 1'b0;
    endtask

    // Call just after the rising edge where bit 0 appears; seq[k] is the k-th line bit.
    task automatic expect_bits(input int sel, input logic [63:0] seq, input int n,
                               input string tag);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk1);
                check($sformatf("%s bit%0d c%0d", tag, k, j), 32'(txd_w[sel]), 32'(seq[k]));
                @(posedge clk1);
            end
        end
    endtask

    // Start together with a push: line must still be high at accept+1, low from accept+2.
    task automatic frame_after_push(input int sel, input logic [63:0] seq, input int n,
                                    input string tag);
        repeat (2) @(posedge clk1);
        @(negedge clk1);
        check({tag, " latency"}, 32'(txd_w[sel]), 32'd1);
        @(posedge clk1);
        expect_bits(sel, seq, n, tag);
    endtask

    task automatic check_idle(input int sel, input string tag);
        @(negedge clk1);
        check({tag, " txd idle"}, 32'(txd_w[sel]), 32'd1);
        check({tag, " busy idle"}, 32'(busy_w[sel]), 32'd0);
        check({tag, " level idle"}, 32'(level_w[sel]), 32'd0);
        repeat (10) @(posedge clk1);
        @(negedge clk1);
        check({tag, " no extra frame"}, 32'(txd_w[sel]), 32'd1);
        @(posedge clk1);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        #1;
        check("reset txd", 32'(txd_w[0]), 32'd1);
        check("reset ready", 32'(ready_w[0]), 32'd1);
        check("reset busy", 32'(busy_w[0]), 32'd0);
        check("reset level", 32'(level_w[0]), 32'd0);
        do_reset();

        // T1: reset in the middle of a low data bit with bytes queued.
        push(8'h00);
        push(8'h11);
        push(8'h22);
        repeat (8) @(posedge clk1);
        @(negedge clk1);
        check("t1 txd low pre", 32'(txd_w[0]), 32'd0);
        check("t1 level pre", 32'(level_w[0]), 32'd2);
        check("t1 busy pre", 32'(busy_w[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t1 txd async", 32'(txd_w[0]), 32'd1);
        check("t1 level async", 32'(level_w[0]), 32'd0);
        check("t1 ready async", 32'(ready_w[0]), 32'd1);
        check("t1 busy async", 32'(busy_w[0]), 32'd0);
        @(negedge clk1);
        rst = 1'b0;
        repeat (20) @(posedge clk1);
        @(negedge clk1);
        check("t1 txd after", 32'(txd_w[0]), 32'd1);
        check("t1 busy after", 32'(busy_w[0]), 32'd0);

        // T2: single byte, no parity.
        do_reset();
        fork
            push(8'hA5);
            frame_after_push(0, 64'b11_0100_1010, 10, "t2");
        join
        check_idle(0, "t2");

        // T3: 0x07 with even and odd parity.
        do_reset();
        fork
            push(8'h07);
            frame_after_push(1, 64'b110_0000_1110, 11, "t3 even");
            frame_after_push(2, 64'b100_0000_1110, 11, "t3 odd");
        join
        check_idle(1, "t3 even");

        // T4: four bytes back to back, the first drains at once so the FIFO never fills.
        do_reset();
        fork
            begin
                push(8'h55);
                check("t4 level1", 32'(level_w[0]), 32'd1);
                push(8'hAA);
                check("t4 level2", 32'(level_w[0]), 32'd1);
                push(8'h0F);
                check("t4 level3", 32'(level_w[0]), 32'd2);
                push(8'hF0);
                check("t4 level4", 32'(level_w[0]), 32'd3);
                check("t4 ready", 32'(ready_w[0]), 32'd1);
                check("t4 busy", 32'(busy_w[0]), 32'd1);
            end
            frame_after_push(0, 64'({frame10(8'hF0), frame10(8'h0F), frame10(8'hAA),
                                     frame10(8'h55)}), 40, "t4");
        join
        check_idle(0, "t4");

        // T5: five pushes fill the FIFO, then hold tx_valid against a full FIFO.
        do_reset();
        fork
            begin
                push(8'h55);
                push(8'hAA);
                push(8'h0F);
                push(8'hF0);
                push(8'h3C);
                check("t5 full level", 32'(level_w[0]), 32'd4);
                check("t5 full ready", 32'(ready_w[0]), 32'd0);
                tx_data  = 8'hEE;
                tx_valid = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(posedge clk1);
                    #1;
                    check($sformatf("t5 hold ready %0d", i), 32'(ready_w[0]), 32'd0);
                    check($sformatf("t5 hold level %0d", i), 32'(level_w[0]), 32'd4);
                end
                tx_valid = 1'b0;
            end
            frame_after_push(0, 64'({frame10(8'h3C), frame10(8'hF0), frame10(8'h0F),
                                     frame10(8'hAA), frame10(8'h55)}), 50, "t5");
        join
        check_idle(0, "t5");

        // T6: two stop bits between two 0x00 frames.
        do_reset();
        fork
            begin
                push(8'h00);
                push(8'h00);
            end
            frame_after_push(3, 64'b0110_0000_0000, 12, "t6");
        join

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
